time_set_writer: RTL

- Time-setting front end: turns debounced push-button levels into an edited hh:mm:ss value.
- Commits the edited value to the time counter through a one-cycle load strobe; it is the writer side of the counter's load interface.
- Sits between the button debouncers / mode handler and the time counter; field and blink outputs drive the display controller.

---
 rtl/time_set_writer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/time_set_writer.sv
`default_nettype none
// ============================================================================
// Module   : time_set_writer
// Purpose  : Time-setting front end. Converts debounced push-button levels
//            into an edited hh:mm:ss value. The value is handed to the time
//            counter through a one-cycle load strobe.
// Ports    : clk, rst_n            - clock, async active-low reset
//            en                    - time-setting mode granted (level)
//            btn_next/up/down/cancel - debounced button levels
//            cur_hour/min/sec      - current time from the counter
//            load, new_hour/min/sec - load strobe and edited value
//            field, blink          - display controller hints
//            busy, done            - editing active / edit finished pulse
// Revision : 1.0 - initial release
// ============================================================================
module time_set_writer #(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int BLINK_CYCLES   = 25_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_cancel,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       load,
  output logic [4:0] new_hour,
  output logic [5:0] new_min,
  output logic [5:0] new_sec,
  output logic [1:0] field,
  output logic       blink,
  output logic       busy,
  output logic       done
);

  localparam int HOLD_W  = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  c_hold      = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]  c_hold_rep  = HOLD_W'(HOLD_CYCLES + REPEAT_CYCLES);
  localparam logic [BLINK_W-1:0] c_blink_end = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [TO_W-1:0]    c_to_end    = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOUR   = 3'd1;
  localparam logic [2:0] S_MIN    = 3'd2;
  localparam logic [2:0] S_SEC    = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  // Button vector order: {cancel, next, up, down}; bits [1:0] auto-repeat.
  logic [3:0]        btn_w;
  logic              armed_q;
  logic [3:0]        prev_q;
  logic [3:0]        ev_q, ev_d;
  logic [HOLD_W-1:0] hold_q [2];
  logic [HOLD_W-1:0] hold_d [2];
  logic [1:0]        rep_w;

  logic [2:0]         state_q, state_d;
  logic [4:0]         hour_q, hour_d;
  logic [5:0]         min_q, min_d;
  logic [5:0]         sec_q, sec_d;
  logic               load_q, load_d;
  logic               done_q, done_d;
  logic               blink_q, blink_d;
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic [TO_W-1:0]    to_q, to_d;

  logic ev_cancel_w, ev_next_w, ev_up_w, ev_dn_w, ev_any_w;
  logic in_edit_q_w, in_edit_d_w, abandon_w, adjust_w, timeout_w;

  assign btn_w = {btn_cancel, btn_next, btn_up, btn_down};

  function automatic logic [4:0] step_hour(input logic [4:0] v, input logic up);
    if (up) step_hour = (v >= 5'd23) ? 5'd0 : v + 5'd1;
    else    step_hour = (v == 5'd0 || v > 5'd23) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] step_60(input logic [5:0] v, input logic up);
    if (up) step_60 = (v >= 6'd59) ? 6'd0 : v + 6'd1;
    else    step_60 = (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
  endfunction

  // Edge and auto-repeat detection. armed_q stays low for the first cycle
  // after reset so a button already held at reset release is taken as the
  // current level rather than a fresh press.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hold_d[i] = '0;
      rep_w[i]  = 1'b0;
      if (armed_q && btn_w[i] && prev_q[i]) begin
        hold_d[i] = hold_q[i] + 1'b1;
        if (hold_d[i] == c_hold) begin
          rep_w[i] = 1'b1;
        end else if (hold_d[i] == c_hold_rep) begin
          // Fold back so the next repeat lands REPEAT_CYCLES later.
          rep_w[i]  = 1'b1;
          hold_d[i] = c_hold;
        end
      end
    end
    ev_d      = {4{armed_q}} & btn_w & ~prev_q;
    ev_d[1:0] = ev_d[1:0] | rep_w;
  end

  // Fixed priority: cancel > next > up > down; losers are dropped.
  assign ev_cancel_w = ev_q[3];
  assign ev_next_w   = ~ev_q[3] & ev_q[2];
  assign ev_up_w     = ~ev_q[3] & ~ev_q[2] & ev_q[1];
  assign ev_dn_w     = ~ev_q[3] & ~ev_q[2] & ~ev_q[1] & ev_q[0];
  assign ev_any_w    = |ev_q;

  assign in_edit_q_w = (state_q == S_HOUR) || (state_q == S_MIN) || (state_q == S_SEC);
  assign in_edit_d_w = (state_d == S_HOUR) || (state_d == S_MIN) || (state_d == S_SEC);
  assign timeout_w   = (to_q == c_to_end);

  always_comb begin
    state_d   = state_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    abandon_w = 1'b0;
    adjust_w  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && ev_next_w) begin
          hour_d  = cur_hour;
          min_d   = cur_min;
          sec_d   = cur_sec;
          state_d = S_HOUR;
        end
      end
      S_HOUR, S_MIN, S_SEC: begin
        if (!en || ev_cancel_w || timeout_w) begin
          state_d   = S_IDLE;
          abandon_w = 1'b1;
        end else if (ev_next_w) begin
          if (state_q == S_HOUR)     state_d = S_MIN;
          else if (state_q == S_MIN) state_d = S_SEC;
          else                       state_d = S_COMMIT;
        end else if (ev_up_w || ev_dn_w) begin
          adjust_w = 1'b1;
          if (state_q == S_HOUR)     hour_d = step_hour(hour_q, ev_up_w);
          else if (state_q == S_MIN) min_d  = step_60(min_q, ev_up_w);
          else                       sec_d  = step_60(sec_q, ev_up_w);
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_d = (state_d == S_COMMIT);
    done_d = (state_d == S_COMMIT) || abandon_w;

    // Inactivity timer restarts on entry to editing and on every event.
    if (!in_edit_q_w || ev_any_w) to_d = '0;
    else                          to_d = to_q + 1'b1;

    // Blink phase restarts on entry and on every adjustment so the value
    // being changed is shown, and is forced off outside the edit states.
    if (!in_edit_q_w || !in_edit_d_w || adjust_w) begin
      bcnt_d  = '0;
      blink_d = 1'b0;
    end else if (bcnt_q == c_blink_end) begin
      bcnt_d  = '0;
      blink_d = ~blink_q;
    end else begin
      bcnt_d  = bcnt_q + 1'b1;
      blink_d = blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      prev_q  <= '0;
      ev_q    <= '0;
      for (int i = 0; i < 2; i++) hold_q[i] <= '0;
      state_q <= S_IDLE;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
      to_q    <= '0;
    end else begin
      armed_q <= 1'b1;
      prev_q  <= btn_w;
      ev_q    <= ev_d;
      for (int i = 0; i < 2; i++) hold_q[i] <= hold_d[i];
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      load_q  <= load_d;
      done_q  <= done_d;
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
      to_q    <= to_d;
    end
  end

  assign load     = load_q;
  assign done     = done_q;
  assign blink    = blink_q;
  assign new_hour = hour_q;
  assign new_min  = min_q;
  assign new_sec  = sec_q;
  assign busy     = in_edit_q_w || (state_q == S_COMMIT);
  assign field    = (state_q == S_HOUR) ? 2'd1 :
                    (state_q == S_MIN)  ? 2'd2 :
                    (state_q == S_SEC)  ? 2'd3 : 2'd0;

endmodule
`default_nettype wire
